// File: rtl/pop_sweep_controller.sv
// pop_sweep_controller: Ramsey / pulse-length scan sequencer for the POP timing generator.
// It steps the selected timer parameter once per measurement point. Each step waits a
// programmable number of completed POP cycles. At the end, or on abort, it steps the
// parameter back to its start value. While idle it passes the front-panel buttons onto the
// same step strobes.
//
// Ports:
//   clk_2M5, reset              2.5 MHz clock, asynchronous active-high reset
//   start, abort                one-cycle sweep begin / early-end requests
//   sweep_target                0 = free precession, 1 = pi/2 (latched on start)
//   num_steps, dwell_cycles     increments per sweep, POP cycles per point (latched on start)
//   sample_in                   POP sample window; its falling edge marks a completed cycle
//   btn_*                       manual one-cycle step requests (honoured only when idle)
//   pieovertwo_*, freeprecess_* step strobes to the timer's up/down counters
//   busy, step_index            sweep active, net increments currently applied
//   point_strobe, done          one-cycle point-complete and sweep-complete tags
module pop_sweep_controller #(
    parameter int unsigned STEP_W    = 8,
    parameter int unsigned DWELL_W   = 8,
    parameter int unsigned PULSE_LEN = 2
) (
    input  logic               clk_2M5,
    input  logic               reset,
    input  logic               start,
    input  logic               abort,
    input  logic               sweep_target,
    input  logic [STEP_W-1:0]  num_steps,
    input  logic [DWELL_W-1:0] dwell_cycles,
    input  logic               sample_in,
    input  logic               btn_pie_plus,
    input  logic               btn_pie_minus,
    input  logic               btn_fp_plus,
    input  logic               btn_fp_minus,
    output logic               pieovertwo_plus,
    output logic               pieovertwo_minus,
    output logic               freeprecess_plus,
    output logic               freeprecess_minus,
    output logic               busy,
    output logic [STEP_W-1:0]  step_index,
    output logic               point_strobe,
    output logic               done
);

    localparam int unsigned      ENG_W    = $clog2(2 * PULSE_LEN + 1);
    localparam logic [ENG_W-1:0] ENG_FULL = ENG_W'(2 * PULSE_LEN);
    localparam logic [ENG_W-1:0] ENG_HIGH = ENG_W'(PULSE_LEN);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SETTLE = 3'd1;
    localparam logic [2:0] S_DWELL  = 3'd2;
    localparam logic [2:0] S_WAITP  = 3'd3;
    localparam logic [2:0] S_RETURN = 3'd4;

    // One-hot strobe selects: {pie_minus, pie_plus, fp_minus, fp_plus}
    localparam logic [3:0] SEL_FP_PLUS   = 4'b0001;
    localparam logic [3:0] SEL_FP_MINUS  = 4'b0010;
    localparam logic [3:0] SEL_PIE_PLUS  = 4'b0100;
    localparam logic [3:0] SEL_PIE_MINUS = 4'b1000;

    logic [2:0]         state_q, state_d;
    logic               sample_prev_q;
    logic [ENG_W-1:0]   eng_cnt_q, eng_cnt_d;
    logic [3:0]         eng_sel_q, eng_sel_d;
    logic               target_q, target_d;
    logic [STEP_W-1:0]  num_q, num_d;
    logic [DWELL_W-1:0] dwell_q, dwell_d;
    logic [DWELL_W-1:0] dwell_cnt_q, dwell_cnt_d;
    logic [STEP_W-1:0]  step_q, step_d;
    logic               point_q, point_d;
    logic               done_q, done_d;

    logic               cyc;
    logic               eng_idle;
    logic               eng_high;
    logic               req;
    logic [3:0]         req_sel;

    // A POP cycle completes on the falling edge of the sample window.
    assign cyc      = sample_prev_q & ~sample_in;
    // The engine counts down 2*PULSE_LEN: strobe high for the upper half, low gap for the rest.
    assign eng_idle = (eng_cnt_q == '0);
    assign eng_high = (eng_cnt_q > ENG_HIGH);

    always_comb begin
        eng_cnt_d = eng_cnt_q;
        eng_sel_d = eng_sel_q;
        if (!eng_idle) begin
            eng_cnt_d = eng_cnt_q - ENG_W'(1);
        end
        if (req && eng_idle) begin
            eng_cnt_d = ENG_FULL;
            eng_sel_d = req_sel;
        end
    end

    always_comb begin
        state_d     = state_q;
        target_d    = target_q;
        num_d       = num_q;
        dwell_d     = dwell_q;
        dwell_cnt_d = dwell_cnt_q;
        step_d      = step_q;
        point_d     = 1'b0;
        done_d      = 1'b0;
        req         = 1'b0;
        req_sel     = 4'b0000;
        case (state_q)
            S_IDLE: begin
                req = btn_pie_plus | btn_pie_minus | btn_fp_plus | btn_fp_minus;
                if (btn_pie_plus) begin
                    req_sel = SEL_PIE_PLUS;
                end else if (btn_pie_minus) begin
                    req_sel = SEL_PIE_MINUS;
                end else if (btn_fp_plus) begin
                    req_sel = SEL_FP_PLUS;
                end else begin
                    req_sel = SEL_FP_MINUS;
                end
                if (start && !abort) begin
                    target_d = sweep_target;
                    num_d    = num_steps;
                    dwell_d  = (dwell_cycles == '0) ? DWELL_W'(1) : dwell_cycles;
                    step_d   = '0;
                    state_d  = S_SETTLE;
                end
            end
            S_SETTLE: begin
                // The first completed cycle straddled the parameter change; drop it.
                if (abort) begin
                    state_d = S_RETURN;
                end else if (cyc) begin
                    dwell_cnt_d = '0;
                    state_d     = S_DWELL;
                end
            end
            S_DWELL: begin
                if (abort) begin
                    state_d = S_RETURN;
                end else if (cyc) begin
                    if (dwell_cnt_q == dwell_q - DWELL_W'(1)) begin
                        point_d = 1'b1;
                        if (step_q == num_q) begin
                            state_d = S_RETURN;
                        end else begin
                            req     = 1'b1;
                            req_sel = target_q ? SEL_PIE_PLUS : SEL_FP_PLUS;
                            step_d  = step_q + STEP_W'(1);
                            state_d = S_WAITP;
                        end
                    end else begin
                        dwell_cnt_d = dwell_cnt_q + DWELL_W'(1);
                    end
                end
            end
            S_WAITP: begin
                // RETURN itself waits for the engine, so an in-flight plus still completes.
                if (abort) begin
                    state_d = S_RETURN;
                end else if (eng_idle) begin
                    state_d = S_SETTLE;
                end
            end
            S_RETURN: begin
                if (eng_idle) begin
                    if (step_q != '0) begin
                        req     = 1'b1;
                        req_sel = target_q ? SEL_PIE_MINUS : SEL_FP_MINUS;
                        step_d  = step_q - STEP_W'(1);
                    end else begin
                        done_d  = 1'b1;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_2M5 or posedge reset) begin
        if (reset) begin
            state_q       <= S_IDLE;
            sample_prev_q <= 1'b0;
            eng_cnt_q     <= '0;
            eng_sel_q     <= '0;
            target_q      <= 1'b0;
            num_q         <= '0;
            dwell_q       <= '0;
            dwell_cnt_q   <= '0;
            step_q        <= '0;
            point_q       <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sample_prev_q <= sample_in;
            eng_cnt_q     <= eng_cnt_d;
            eng_sel_q     <= eng_sel_d;
            target_q      <= target_d;
            num_q         <= num_d;
            dwell_q       <= dwell_d;
            dwell_cnt_q   <= dwell_cnt_d;
            step_q        <= step_d;
            point_q       <= point_d;
            done_q        <= done_d;
        end
    end

    assign freeprecess_plus  = eng_high & eng_sel_q[0];
    assign freeprecess_minus = eng_high & eng_sel_q[1];
    assign pieovertwo_plus   = eng_high & eng_sel_q[2];
    assign pieovertwo_minus  = eng_high & eng_sel_q[3];
    assign busy              = (state_q != S_IDLE);
    assign step_index        = step_q;
    assign point_strobe      = point_q;
    assign done              = done_q;

endmodule

// File: tb/tb_pop_sweep_controller.sv
// Self-checking bench for pop_sweep_controller: directed scenarios plus randomized sweeps.
// A behavioural model predicts the outputs after every clock edge.
module tb_pop_sweep_controller;

    localparam int STEP_W   = 8;
    localparam int DWELL_W  = 8;
    localparam int PL       = 2;
    localparam int FREE_GAP = 2 * PL + 1;  // a new strobe may rise this many edges after the last

    logic               clk_2M5 = 1'b0;
    logic               reset = 1'b1;
    logic               start = 1'b0;
    logic               abort = 1'b0;
    logic               sweep_target = 1'b0;
    logic [STEP_W-1:0]  num_steps = '0;
    logic [DWELL_W-1:0] dwell_cycles = '0;
    logic               sample_in = 1'b0;
    logic               btn_pie_plus = 1'b0;
    logic               btn_pie_minus = 1'b0;
    logic               btn_fp_plus = 1'b0;
    logic               btn_fp_minus = 1'b0;
    logic               pieovertwo_plus, pieovertwo_minus, freeprecess_plus, freeprecess_minus;
    logic               busy;
    logic [STEP_W-1:0]  step_index;
    logic               point_strobe, done;

    always #5 clk_2M5 = ~clk_2M5;

    pop_sweep_controller #(
        .STEP_W   (STEP_W),
        .DWELL_W  (DWELL_W),
        .PULSE_LEN(PL)
    ) dut (
        .clk_2M5          (clk_2M5),
        .reset            (reset),
        .start            (start),
        .abort            (abort),
        .sweep_target     (sweep_target),
        .num_steps        (num_steps),
        .dwell_cycles     (dwell_cycles),
        .sample_in        (sample_in),
        .btn_pie_plus     (btn_pie_plus),
        .btn_pie_minus    (btn_pie_minus),
        .btn_fp_plus      (btn_fp_plus),
        .btn_fp_minus     (btn_fp_minus),
        .pieovertwo_plus  (pieovertwo_plus),
        .pieovertwo_minus (pieovertwo_minus),
        .freeprecess_plus (freeprecess_plus),
        .freeprecess_minus(freeprecess_minus),
        .busy             (busy),
        .step_index       (step_index),
        .point_strobe     (point_strobe),
        .done             (done)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: mode 0 idle, 1 measuring points, 2 stepping back to the start value.
    int t_now = 0;
    int m_mode = 0, m_n = 0, m_d = 1, m_tgt = 0, m_discard = 0, m_count = 0, m_steps = 0;
    int m_last_rise = -100, m_last_kind = 0, m_ret_start = 0;
    bit m_prev = 1'b0;
    bit e_point = 1'b0, e_done = 1'b0;

    // Stimulus state: sample_in half period (0 = random each half), random traffic enable.
    int sample_half = 100;
    int half_left   = 100;
    bit s_rose      = 1'b0;
    bit rand_en     = 1'b0;

    // Observed DUT activity, compared against literal expectations per scenario.
    int       obs_rise[4];
    int       obs_high[4];
    int       obs_point, obs_done;
    bit       busy_seen;
    logic [3:0] p_str = 4'b0000;
    int       step_seq[$];
    int       last_step;
    int       exp_seq[7] = '{0, 1, 2, 3, 2, 1, 0};

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, exp, t_now);
        end
    endtask

    task automatic fail_timeout(input string name, input int budget);
        n_tests++;
        n_fail++;
        $display("FAIL timeout_%s: condition not reached within %0d cycles", name, budget);
    endtask

    function automatic int exp_strobe(input int k);
        return ((k == m_last_kind) && (t_now - m_last_rise < PL)) ? 1 : 0;
    endfunction

    // Advance the model by one clock edge using the inputs currently applied.
    task automatic model_step();
        bit cyc, free;
        int kind;
        t_now++;
        e_point = 1'b0;
        e_done  = 1'b0;
        kind    = -1;
        cyc     = m_prev && !sample_in;
        m_prev  = sample_in;
        free    = (t_now - m_last_rise) >= FREE_GAP;
        case (m_mode)
            0: begin
                if (free) begin
                    if (btn_pie_plus) kind = 2;
                    else if (btn_pie_minus) kind = 3;
                    else if (btn_fp_plus) kind = 0;
                    else if (btn_fp_minus) kind = 1;
                end
                if (start && !abort) begin
                    m_mode    = 1;
                    m_tgt     = int'(sweep_target);
                    m_n       = int'(num_steps);
                    m_d       = (dwell_cycles == '0) ? 1 : int'(dwell_cycles);
                    m_discard = 1;
                    m_count   = 0;
                    m_steps   = 0;
                end
            end
            1: begin
                if (abort) begin
                    m_mode      = 2;
                    m_ret_start = t_now;
                end else if (cyc) begin
                    if (m_discard != 0) begin
                        m_discard = 0;
                    end else begin
                        m_count++;
                        if (m_count == m_d) begin
                            e_point   = 1'b1;
                            m_count   = 0;
                            m_discard = 1;
                            if (m_steps == m_n) begin
                                m_mode      = 2;
                                m_ret_start = t_now;
                            end else begin
                                kind = (m_tgt != 0) ? 2 : 0;
                                m_steps++;
                            end
                        end
                    end
                end
            end
            default: begin
                if (t_now > m_ret_start && free) begin
                    if (m_steps != 0) begin
                        kind = (m_tgt != 0) ? 3 : 1;
                        m_steps--;
                    end else begin
                        e_done = 1'b1;
                        m_mode = 0;
                    end
                end
            end
        endcase
        if (kind >= 0) begin
            m_last_rise = t_now;
            m_last_kind = kind;
        end
    endtask

    task automatic model_reset();
        m_mode      = 0;
        m_steps     = 0;
        m_last_rise = t_now - 100;
        m_prev      = 1'b0;
        e_point     = 1'b0;
        e_done      = 1'b0;
        p_str       = 4'b0000;
    endtask

    task automatic compare_all();
        logic [3:0] cur;
        chk("freeprecess_plus", int'(freeprecess_plus), exp_strobe(0));
        chk("freeprecess_minus", int'(freeprecess_minus), exp_strobe(1));
        chk("pieovertwo_plus", int'(pieovertwo_plus), exp_strobe(2));
        chk("pieovertwo_minus", int'(pieovertwo_minus), exp_strobe(3));
        chk("busy", int'(busy), (m_mode != 0) ? 1 : 0);
        chk("step_index", int'(step_index), m_steps);
        chk("point_strobe", int'(point_strobe), int'(e_point));
        chk("done", int'(done), int'(e_done));
        cur = {pieovertwo_minus, pieovertwo_plus, freeprecess_minus, freeprecess_plus};
        for (int k = 0; k < 4; k++) begin
            if (cur[k] && !p_str[k]) obs_rise[k]++;
            if (cur[k]) obs_high[k]++;
        end
        p_str = cur;
        if (point_strobe) obs_point++;
        if (done) obs_done++;
        if (busy) busy_seen = 1'b1;
        if (int'(step_index) != last_step) begin
            last_step = int'(step_index);
            step_seq.push_back(last_step);
        end
    endtask

    task automatic clear_obs();
        for (int k = 0; k < 4; k++) begin
            obs_rise[k] = 0;
            obs_high[k] = 0;
        end
        obs_point = 0;
        obs_done  = 0;
        busy_seen = 1'b0;
        step_seq.delete();
        last_step = int'(step_index);
        step_seq.push_back(last_step);
    endtask

    task automatic sample_next();
        s_rose = 1'b0;
        if (half_left <= 1) begin
            sample_in = ~sample_in;
            s_rose    = sample_in;
            half_left = (sample_half > 0) ? sample_half : int'($urandom_range(8, 40));
        end else begin
            half_left--;
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk_2M5);
        #1;
        compare_all();
        start         = 1'b0;
        abort         = 1'b0;
        btn_pie_plus  = 1'b0;
        btn_pie_minus = 1'b0;
        btn_fp_plus   = 1'b0;
        btn_fp_minus  = 1'b0;
        if (rand_en) begin
            btn_pie_plus  = ($urandom_range(0, 15) == 0);
            btn_pie_minus = ($urandom_range(0, 15) == 0);
            btn_fp_plus   = ($urandom_range(0, 15) == 0);
            btn_fp_minus  = ($urandom_range(0, 15) == 0);
            sweep_target  = ($urandom_range(0, 1) == 1);
            num_steps     = STEP_W'($urandom);
            dwell_cycles  = DWELL_W'($urandom);
        end
        sample_next();
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_pieovertwo_plus"}, int'(pieovertwo_plus), 0);
        chk({tag, "_pieovertwo_minus"}, int'(pieovertwo_minus), 0);
        chk({tag, "_freeprecess_plus"}, int'(freeprecess_plus), 0);
        chk({tag, "_freeprecess_minus"}, int'(freeprecess_minus), 0);
        chk({tag, "_busy"}, int'(busy), 0);
        chk({tag, "_step_index"}, int'(step_index), 0);
        chk({tag, "_point_strobe"}, int'(point_strobe), 0);
        chk({tag, "_done"}, int'(done), 0);
    endtask

    task automatic do_start(input bit tgt, input int n, input int d);
        btn_pie_plus  = 1'b0;
        btn_pie_minus = 1'b0;
        btn_fp_plus   = 1'b0;
        btn_fp_minus  = 1'b0;
        abort         = 1'b0;
        start         = 1'b1;
        sweep_target  = tgt;
        num_steps     = STEP_W'(n);
        dwell_cycles  = DWELL_W'(d);
        tick();
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (m_mode != 0 && n < budget) begin
            if (rand_en && m_mode == 1 && s_rose && $urandom_range(0, 40) == 0) abort = 1'b1;
            tick();
            n++;
        end
        if (m_mode != 0) fail_timeout(name, budget);
    endtask

    initial begin
        int n;
        // Reset state
        #2;
        chk_zero("reset");
        @(posedge clk_2M5);
        #1;
        reset = 1'b0;
        model_reset();

        // Manual button: one 2-cycle strobe; a button one cycle later is dropped.
        clear_obs();
        btn_fp_plus = 1'b1;
        tick();
        btn_pie_plus = 1'b1;
        tick();
        idle_ticks(10);
        chk("t1_fp_plus_pulses", obs_rise[0], 1);
        chk("t1_fp_plus_high_cycles", obs_high[0], 2);
        chk("t1_pie_plus_pulses", obs_rise[2], 0);
        chk("t1_busy_seen", int'(busy_seen), 0);

        // Free-precession sweep, 3 steps, dwell 2, sample toggling every 100 cycles.
        clear_obs();
        do_start(1'b0, 3, 2);
        wait_idle("t2", 4000);
        idle_ticks(3);
        chk("t2_points", obs_point, 4);
        chk("t2_fp_plus_pulses", obs_rise[0], 3);
        chk("t2_fp_minus_pulses", obs_rise[1], 3);
        chk("t2_pie_pulses", obs_rise[2] + obs_rise[3], 0);
        chk("t2_done", obs_done, 1);
        chk("t2_step_seq_len", step_seq.size(), 7);
        for (int i = 0; i < 7; i++) begin
            chk($sformatf("t2_step_seq_%0d", i), (i < step_seq.size()) ? step_seq[i] : -1,
                exp_seq[i]);
        end

        // Zero-step sweep with dwell 0 treated as 1.
        clear_obs();
        do_start(1'b1, 0, 0);
        wait_idle("t3", 1000);
        idle_ticks(2);
        chk("t3_points", obs_point, 1);
        chk("t3_strobes", obs_rise[0] + obs_rise[1] + obs_rise[2] + obs_rise[3], 0);
        chk("t3_done", obs_done, 1);
        chk("t3_busy_after", int'(busy), 0);

        // Abort in DWELL at step 2, second abort during RETURN is ignored.
        clear_obs();
        do_start(1'b1, 5, 1);
        n = 0;
        while (!(m_steps == 2 && m_mode == 1 && m_discard == 0 && s_rose) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) fail_timeout("t4_dwell2", 3000);
        abort = 1'b1;
        tick();
        n = 0;
        while (!pieovertwo_minus && n < 100) begin
            tick();
            n++;
        end
        if (n >= 100) fail_timeout("t4_first_minus", 100);
        abort = 1'b1;
        tick();
        wait_idle("t4", 200);
        idle_ticks(2);
        chk("t4_pie_plus_pulses", obs_rise[2], 2);
        chk("t4_pie_minus_pulses", obs_rise[3], 2);
        chk("t4_points", obs_point, 2);
        chk("t4_done", obs_done, 1);

        // start and abort together: nothing happens.
        clear_obs();
        start = 1'b1;
        abort = 1'b1;
        num_steps = 8'd3;
        tick();
        idle_ticks(5);
        chk("t5_busy_seen", int'(busy_seen), 0);
        chk("t5_done", obs_done, 0);

        // Reset in the middle of a minus strobe, then a clean sweep.
        do_start(1'b0, 2, 1);
        n = 0;
        while (!(m_mode == 2 && freeprecess_minus) && n < 3000) begin
            tick();
            n++;
        end
        if (n >= 3000) fail_timeout("t6_return", 3000);
        #2;
        reset = 1'b1;
        #1;
        chk_zero("t6_midreset");
        @(posedge clk_2M5);
        @(posedge clk_2M5);
        #1;
        reset = 1'b0;
        model_reset();
        clear_obs();
        do_start(1'b0, 2, 1);
        wait_idle("t6", 3000);
        idle_ticks(2);
        chk("t6_fp_plus_pulses", obs_rise[0], 2);
        chk("t6_fp_minus_pulses", obs_rise[1], 2);
        chk("t6_points", obs_point, 3);
        chk("t6_done", obs_done, 1);

        // Randomized sweeps with button noise, random aborts and random sample timing.
        rand_en     = 1'b1;
        sample_half = 0;
        half_left   = 8;
        for (int i = 0; i < 10; i++) begin
            idle_ticks(int'($urandom_range(0, 20)));
            if ($urandom_range(0, 3) == 0) begin
                start = 1'b1;
                abort = 1'b1;
                tick();
            end
            do_start($urandom_range(0, 1) == 1, int'($urandom_range(0, 6)),
                     int'($urandom_range(0, 3)));
            wait_idle("random", 20000);
        end
        rand_en = 1'b0;
        idle_ticks(10);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pop_sweep_controller.md
Name: pop_sweep_controller

Overview:
- Automatic Ramsey/pulse-length scan sequencer for the POP timing generator.
- Drives the four step strobes (pi/2 plus/minus, free-precession plus/minus) that adjust the timer's preloadable up/down counters.
- At each setting it waits for a programmable number of completed POP cycles, then steps the selected parameter.
- After the scan it steps the parameter back to its start value; it also arbitrates the front-panel buttons onto the same strobes.

Parameters:
- STEP_W, 8, width of step count and step index.
- DWELL_W, 8, width of dwell-cycle count.
- PULSE_LEN, 2, clk_2M5 cycles a step strobe is high; minimum low gap after each strobe is also PULSE_LEN.

Ports:
- clk_2M5  in  1  2.5 MHz system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request to begin a sweep; honoured only in IDLE.
- abort  in  1  one-cycle request to end the sweep early and restore the start value.
- sweep_target  in  1  0 = free precession, 1 = pi/2; latched on start.
- num_steps  in  STEP_W  number of increments in the sweep; latched on start.
- dwell_cycles  in  DWELL_W  completed POP cycles measured per point; latched on start.
- sample_in  in  1  POP sample window, already synchronous to clk_2M5.
- btn_pie_plus, btn_pie_minus, btn_fp_plus, btn_fp_minus  in  1 each  manual one-cycle strobes.
- pieovertwo_plus, pieovertwo_minus, freeprecess_plus, freeprecess_minus  out  1 each  step strobes to the timer.
- busy  out  1  high in every state except IDLE.
- step_index  out  STEP_W  net increments currently applied.
- point_strobe  out  1  one cycle when a point's dwell completes (DAQ tag).
- done  out  1  one cycle on return to IDLE after a sweep.

Behaviour:
- Reset values: all outputs 0; state IDLE; sample_in history register 0.
- Cycle-complete event (cyc):
  - sample_in registered; cyc = prev & ~sample_in, i.e. the falling edge of the sample window.
  - 1-cycle detection latency.
- Strobe engine:
  - One request raises exactly one output for PULSE_LEN cycles, then holds it low PULSE_LEN cycles.
  - The engine is busy for 2*PULSE_LEN cycles and accepts no new request while busy.
  - Output selection: target 0 drives freeprecess_plus/minus; target 1 drives pieovertwo_plus/minus.
- States:
  - IDLE
    - Manual buttons pass through the strobe engine. A button arriving while the engine is busy is dropped.
    - Priority when buttons coincide: pie_plus > pie_minus > fp_plus > fp_minus; the others are dropped.
    - start with abort low: latch inputs; dwell_cycles = 0 is treated as 1; step_index = 0; go to SETTLE.
    - start and abort in the same cycle: abort wins and the block stays in IDLE.
  - SETTLE
    - Discard the first cyc, because that POP cycle straddled the parameter change. Then go to DWELL with the dwell counter at 0.
  - DWELL
    - Count cyc events.
    - On reaching the latched dwell value, pulse point_strobe.
    - If step_index == latched num_steps, go to RETURN.
    - Otherwise issue a plus strobe, step_index + 1, and go to WAITP.
  - WAITP
    - Wait for the strobe engine to go idle, then go to SETTLE.
  - RETURN
    - While step_index ≠ 0 and the engine is idle: issue a minus strobe and decrement step_index.
    - When step_index == 0 and the engine is idle: pulse done and go to IDLE.
- Manual buttons are dropped in every state except IDLE; the sweep owns the strobes while busy.
- Abort in SETTLE, DWELL or WAITP:
  - Any strobe in flight completes first, then the block goes to RETURN.
  - The increment already counted stays in step_index, so every applied plus is undone.
  - Abort during RETURN is ignored.
- Sweep size: num_steps + 1 measurement points and 2*num_steps strobes per sweep.
  - num_steps = 0: one point, no strobes, then done.
- step_index never wraps. The maximum num_steps is 2^STEP_W − 1.
- Reset mid-sweep: immediate return to reset values; strobes go low asynchronously. The timer's counters are not restored; the system asserts load_defaults to restore them.

Test Plan:
- Reset, then pulse btn_fp_plus → freeprecess_plus high exactly 2 cycles; a second button 1 cycle later is dropped; busy stays 0.
- start with target=0, num_steps=3, dwell=2, sample_in toggling every 100 cycles:
  - 4 point_strobe pulses, each after 2 counted cyc with the first cyc after every step discarded.
  - freeprecess_plus ×3, then freeprecess_minus ×3, then done; step_index sequence 0,1,2,3,2,1,0.
- target=1, num_steps=0, dwell=0 → one point_strobe after 1 counted cyc; no strobes; done; busy falls.
- target=1, num_steps=5; abort in DWELL with step_index=2, then again during RETURN → exactly 2 pieovertwo_minus; the second abort has no effect; done.
- start and abort asserted together in IDLE → no state change; busy stays 0.
- Assert reset mid-strobe during RETURN → all outputs 0 within the same cycle; a subsequent start runs a full sweep normally.
